// File: rtl/i2c_slave_fsm_pkg.sv
// ----------------------------------------------------------------------------
// i2c_slave_fsm_pkg
//   Shared I2C definitions for the slave controller and the master-side
//   blocks: controller state encoding, bus ACK/NACK levels, R/W bit values
//   and a small address-compare helper.
// ----------------------------------------------------------------------------
package i2c_slave_fsm_pkg;

   // Controller states. Encoding is fixed so that state_o can be decoded by
   // anything observing the debug port without importing this package.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WRITE     = 3'd3,
      ST_WR_ACK    = 3'd4,
      ST_READ      = 3'd5,
      ST_RD_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } state_e;

   // SDA level during the ninth clock of a byte.
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   // R/W bit (LSB of the address byte).
   localparam logic I2C_RD = 1'b1;
   localparam logic I2C_WR = 1'b0;

   // Address byte {addr[6:0], rw} matches the given own address.
   // There is no general call: 7'h00 only matches an own address of 7'h00.
   function automatic logic addr_matches(input logic [7:0] addr_byte,
                                         input logic [6:0] own_addr);
      return (addr_byte[7:1] == own_addr);
   endfunction

endpackage : i2c_slave_fsm_pkg

// File: rtl/i2c_line_filter.sv
// ----------------------------------------------------------------------------
// i2c_line_filter
//   Conditions one raw I2C pin for use on the system clock: two-flop
//   synchroniser, then a glitch filter that only accepts a new level after
//   FILT_LEN consecutive equal samples, then rise/fall pulses aligned with the
//   filtered level change. Pin-to-event latency is 2 + FILT_LEN clocks.
//
// Ports
//   clk_i    in   1  system clock
//   rst_i    in   1  synchronous active-high reset (line assumed idle-high)
//   pin_i    in   1  raw asynchronous pin
//   level_o  out  1  filtered level
//   rise_o   out  1  one-clk pulse, filtered level went 0->1
//   fall_o   out  1  one-clk pulse, filtered level went 1->0
// ----------------------------------------------------------------------------
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q counts how many consecutive synchronised samples already disagree
   // with the filtered level; the FILT_LEN-th disagreeing sample flips it.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_MAX) begin
            filt_d = sync2_q;
            rise_d = sync2_q;
            fall_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = filt_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule : i2c_line_filter

// File: rtl/i2c_slave_fsm.sv
// ----------------------------------------------------------------------------
// i2c_slave_fsm
//   Clock-synchronous I2C slave. SCL/SDA are oversampled and filtered on clk,
//   START/STOP are detected, a runtime 7-bit address is matched and ACKed,
//   master writes land in rx_data and master reads return tx_data.
//   Requires clk >= 20x the SCL rate.
//
// Ports
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  synchronous active-high reset
//   slave_addr  in   7  own address, compared on the 8th address SCL rise
//   scl_in      in   1  raw SCL pin
//   sda_in      in   1  raw SDA pin
//   sda_oe      out  1  1 = pull SDA low
//   tx_data     in   8  byte returned on read, loaded at each byte start
//   rx_data     out  8  last byte written by the master
//   rx_valid    out  1  one-clk pulse when rx_data updates
//   addr_hit    out  1  one-clk pulse on address match
//   busy        out  1  state != IDLE
//   state_o     out  3  current controller state (debug)
//
// Handshake: there is no flow control toward the fabric. rx_valid is a
// single-cycle qualifier for rx_data; tx_data must be stable whenever a read
// byte starts (ACK-end SCL fall, or SCL fall after a master ACK).
// ----------------------------------------------------------------------------
module i2c_slave_fsm
   import i2c_slave_fsm_pkg::*;
#(
   parameter int         FILT_LEN = 3,
   parameter logic [7:0] RX_RST   = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] slave_addr,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_hit,
   output logic       busy,
   output state_e     state_o
);

   // ------------------------------------------------------------------
   // Line conditioning
   // ------------------------------------------------------------------
   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk_i   (clk),
      .rst_i   (rst),
      .pin_i   (scl_in),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk_i   (clk),
      .rst_i   (rst),
      .pin_i   (sda_in),
      .level_o (sda_lvl),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   // SDA may only move while SCL is low, so any SDA edge with SCL high is a
   // bus condition. Both take priority over bit handling in the same clk.
   logic start_ev, stop_ev;
   assign start_ev = sda_fall & scl_lvl;
   assign stop_ev  = sda_rise & scl_lvl;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;      // bits received so far in this byte
   logic [7:0] tx_sh_q, tx_sh_d;      // remaining read bits, next at [7]
   logic       rw_q, rw_d;
   logic       phase_q, phase_d;      // ACK states: ACK driven; READ: byte done
   logic       load_q, load_d;        // READ: reload tx_data on next fall
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       addr_hit_q, addr_hit_d;

   // Byte being completed on this SCL rise and whether it addresses us.
   logic [7:0] shift_nxt;
   logic       byte_end;
   logic       addr_match;

   assign shift_nxt  = {shift_q, sda_lvl};
   assign byte_end   = (bit_cnt_q == 3'd7);
   assign addr_match = addr_matches(shift_nxt, slave_addr);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (start_ev) begin
         state_d = ST_ADDR;
      end else if (stop_ev) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_ADDR: begin
               if (scl_rise && byte_end) begin
                  state_d = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall && phase_q) begin
                  state_d = (rw_q == I2C_RD) ? ST_READ : ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (scl_rise && byte_end) begin
                  state_d = ST_WR_ACK;
               end
            end
            ST_WR_ACK: begin
               if (scl_fall && phase_q) begin
                  state_d = ST_WRITE;
               end
            end
            ST_READ: begin
               if (scl_fall && phase_q && !load_q) begin
                  state_d = ST_RD_ACK;
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  state_d = (sda_lvl == I2C_NACK) ? ST_WAIT_STOP : ST_READ;
               end
            end
            ST_WAIT_STOP: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output / datapath logic
   // ------------------------------------------------------------------
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_sh_d    = tx_sh_q;
      rw_d       = rw_q;
      phase_d    = phase_q;
      load_d     = load_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      addr_hit_d = 1'b0;

      if (start_ev) begin
         bit_cnt_d = 3'd0;
         phase_d   = 1'b0;
         load_d    = 1'b0;
         sda_oe_d  = 1'b0;
      end else if (stop_ev) begin
         phase_d  = 1'b0;
         load_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sda_oe_d = 1'b0;
            end

            ST_ADDR: begin
               sda_oe_d = 1'b0;
               if (scl_rise) begin
                  shift_d   = shift_nxt[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (byte_end && addr_match) begin
                     addr_hit_d = 1'b1;
                     rw_d       = shift_nxt[0];
                     phase_d    = 1'b0;
                  end
               end
            end

            // First fall after the byte: pull SDA for the ACK clock.
            // Second fall: release (write) or present the first read bit.
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_oe_d = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     phase_d = 1'b0;
                     if (rw_q == I2C_RD) begin
                        sda_oe_d = ~tx_data[7];
                        tx_sh_d  = {tx_data[6:0], 1'b0};
                     end else begin
                        sda_oe_d = 1'b0;
                     end
                  end
               end
            end

            ST_WRITE: begin
               if (scl_rise) begin
                  shift_d   = shift_nxt[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (byte_end) begin
                     rx_data_d  = shift_nxt;
                     rx_valid_d = 1'b1;
                     phase_d    = 1'b0;
                  end
               end
            end

            ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_oe_d = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     phase_d  = 1'b0;
                  end
               end
            end

            // Bit 7 is already on the bus when READ is entered from the
            // address ACK; after a master ACK it is loaded on the first fall.
            ST_READ: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (byte_end) begin
                     phase_d = 1'b1;
                  end
               end else if (scl_fall) begin
                  if (load_q) begin
                     load_d   = 1'b0;
                     sda_oe_d = ~tx_data[7];
                     tx_sh_d  = {tx_data[6:0], 1'b0};
                  end else if (phase_q) begin
                     phase_d  = 1'b0;
                     sda_oe_d = 1'b0;
                  end else begin
                     sda_oe_d = ~tx_sh_q[7];
                     tx_sh_d  = {tx_sh_q[6:0], 1'b0};
                  end
               end
            end

            ST_RD_ACK: begin
               sda_oe_d = 1'b0;
               if (scl_rise && (sda_lvl == I2C_ACK)) begin
                  load_d = 1'b1;
               end
            end

            ST_WAIT_STOP: begin
               sda_oe_d = 1'b0;
            end

            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'd0;
         tx_sh_q    <= 8'd0;
         rw_q       <= I2C_WR;
         phase_q    <= 1'b0;
         load_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= RX_RST;
         rx_valid_q <= 1'b0;
         addr_hit_q <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_sh_q    <= tx_sh_d;
         rw_q       <= rw_d;
         phase_q    <= phase_d;
         load_q     <= load_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         addr_hit_q <= addr_hit_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign addr_hit = addr_hit_q;
   assign busy     = (state_q != ST_IDLE);
   assign state_o  = state_q;

endmodule : i2c_slave_fsm

// File: tb/tb_i2c_slave_fsm.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_fsm
//   Bench for i2c_slave_fsm: an open-drain I2C master model drives the pins,
//   written bytes are queued as expected rx_data values and popped by a
//   monitor on each rx_valid pulse, and master-side reads/ACKs are compared
//   with a transaction-level model of the slave.
// ----------------------------------------------------------------------------
module tb_i2c_slave_fsm;
   import i2c_slave_fsm_pkg::*;

   localparam int         Q        = 10;     // clks per quarter SCL period
   localparam logic [7:0] RX_RST_V = 8'h00;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [6:0] slave_addr = 7'h00;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       addr_hit;
   logic       busy;
   state_e     state_o;
   state_e     prev_state;

   assign sda_bus = m_sda & ~sda_oe;

   i2c_slave_fsm #(.FILT_LEN(3), .RX_RST(RX_RST_V)) dut (
      .clk        (clk),
      .rst        (rst),
      .slave_addr (slave_addr),
      .scl_in     (m_scl),
      .sda_in     (sda_bus),
      .sda_oe     (sda_oe),
      .tx_data    (tx_data),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .addr_hit   (addr_hit),
      .busy       (busy),
      .state_o    (state_o)
   );

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_rx_q[$];
   logic [7:0] model_rx = RX_RST_V;
   int         exp_hits = 0;
   int         act_hits = 0;
   int         exp_entries = 0;
   int         act_entries = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            if (exp_rx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_valid: unexpected pulse, rx_data=%0h, no byte expected", rx_data);
            end else begin
               check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
            end
         end
         if (addr_hit) act_hits++;
         if (state_o == ST_ADDR && prev_state != ST_ADDR) act_entries++;
      end
      prev_state <= state_o;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_out(input logic b);
      m_sda = b;
      wait_clks(Q);
      m_scl = 1'b1;
      wait_clks(2 * Q);
      m_scl = 1'b0;
      wait_clks(Q);
   endtask

   task automatic bit_in(output logic b);
      m_sda = 1'b1;
      wait_clks(Q);
      m_scl = 1'b1;
      wait_clks(Q);
      b = sda_bus;
      wait_clks(Q);
      m_scl = 1'b0;
      wait_clks(Q);
   endtask

   // Works from idle (SCL high) and as a repeated START (SCL low).
   task automatic start_cond();
      if (m_scl == 1'b0) begin
         m_sda = 1'b1;
         wait_clks(Q);
         m_scl = 1'b1;
         wait_clks(Q);
      end
      m_sda = 1'b0;
      wait_clks(Q);
      m_scl = 1'b0;
      wait_clks(Q);
      exp_entries++;
   endtask

   task automatic stop_cond();
      m_sda = 1'b0;
      wait_clks(Q);
      m_scl = 1'b1;
      wait_clks(Q);
      m_sda = 1'b1;
      wait_clks(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) bit_out(b[i]);
      bit_in(ack);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic master_nack);
      logic v;
      for (int i = 7; i >= 0; i--) begin
         bit_in(v);
         b[i] = v;
      end
      bit_out(master_nack);
   endtask

   // ---------------- transaction model ----------------
   // The slave ACKs an address byte iff its upper seven bits equal the own
   // address; after that it ACKs every written byte and returns tx_data on
   // reads. An unaddressed slave leaves SDA alone, so the master sees 1s.
   task automatic addr_phase(input logic [7:0] abyte, output logic m);
      logic ack;
      m = ((abyte >> 1) == {1'b0, slave_addr});
      if (m) exp_hits++;
      start_cond();
      write_byte(abyte, ack);
      check("addr_ack", {31'd0, ack}, m ? 32'd0 : 32'd1);
   endtask

   task automatic wr_data(input logic [7:0] d, input logic m);
      logic ack;
      if (m) begin
         exp_rx_q.push_back(d);
         model_rx = d;
      end
      write_byte(d, ack);
      check("wr_ack", {31'd0, ack}, m ? 32'd0 : 32'd1);
   endtask

   task automatic rd_data(input logic m, input logic last);
      logic [7:0] got;
      read_byte(got, last);
      check("rd_data", {24'd0, got}, m ? {24'd0, tx_data} : 32'hFF);
   endtask

   task automatic end_checks();
      check("busy_end", {31'd0, busy}, 32'd0);
      check("state_end", 32'(state_o), 32'(ST_IDLE));
      check("sda_oe_end", {31'd0, sda_oe}, 32'd0);
      check("rx_pending", exp_rx_q.size(), 32'd0);
      check("rx_hold", {24'd0, rx_data}, {24'd0, model_rx});
      check("addr_hits", act_hits, exp_hits);
      check("addr_entries", act_entries, exp_entries);
   endtask

   task automatic watch_busy(input int n, output logic saw);
      saw = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (busy) saw = 1'b1;
      end
   endtask

   task automatic random_txn();
      logic [6:0] sa, a7;
      logic       match, rw, m;
      int         n;
      sa    = 7'($urandom_range(0, 127));
      match = ($urandom_range(0, 9) < 7);
      a7    = sa;
      if (!match) begin
         while (a7 == sa) a7 = 7'($urandom_range(0, 127));
      end
      rw         = 1'($urandom_range(0, 1));
      n          = $urandom_range(1, 3);
      slave_addr = sa;
      tx_data    = 8'($urandom_range(0, 255));
      addr_phase({a7, rw}, m);
      for (int i = 0; i < n; i++) begin
         if (rw == I2C_WR) wr_data(8'($urandom_range(0, 255)), m);
         else              rd_data(m, (i == n - 1));
      end
      stop_cond();
      end_checks();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic       m, saw;
      logic [7:0] abyte;

      // Reset values
      rst = 1'b1;
      wait_clks(5);
      check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, {24'd0, RX_RST_V});
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_addr_hit", {31'd0, addr_hit}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_state", 32'(state_o), 32'(ST_IDLE));
      rst = 1'b0;
      wait_clks(10);

      // Two-byte write to own address
      slave_addr = 7'h27;
      addr_phase(8'h4E, m);
      wr_data(8'h4E, m);
      wr_data(8'hA5, m);
      stop_cond();
      check("wr_last", {24'd0, rx_data}, 32'hA5);
      end_checks();

      // Foreign address: no ACK, ignored until STOP
      addr_phase(8'h50, m);
      check("nack_state", 32'(state_o), 32'(ST_WAIT_STOP));
      stop_cond();
      end_checks();

      // Two-byte read, master ACK then NACK
      tx_data = 8'h3C;
      addr_phase(8'h4F, m);
      rd_data(m, 1'b0);
      rd_data(m, 1'b1);
      check("rd_nack_sda", {31'd0, sda_oe}, 32'd0);
      check("rd_nack_state", 32'(state_o), 32'(ST_WAIT_STOP));
      stop_cond();
      end_checks();

      // Write, repeated START, read
      tx_data = 8'hD2;
      addr_phase(8'h4E, m);
      wr_data(8'h11, m);
      addr_phase(8'h4F, m);
      rd_data(m, 1'b1);
      stop_cond();
      check("rs_rx", {24'd0, rx_data}, 32'h11);
      end_checks();

      // Glitch filter: 1-clk SDA dip with SCL high is not a START
      m_sda = 1'b0;
      wait_clks(1);
      m_sda = 1'b1;
      watch_busy(15, saw);
      check("glitch_start", {31'd0, saw}, 32'd0);
      // 3-clk dip is a START followed by a STOP
      m_sda = 1'b0;
      wait_clks(3);
      m_sda = 1'b1;
      exp_entries++;
      watch_busy(15, saw);
      check("pulse_start", {31'd0, saw}, 32'd1);
      check("pulse_stop", 32'(state_o), 32'(ST_IDLE));
      // 1-clk SDA spike with SCL high after a START is not a STOP
      m_sda = 1'b0;
      exp_entries++;
      wait_clks(Q);
      m_sda = 1'b1;
      wait_clks(1);
      m_sda = 1'b0;
      wait_clks(Q);
      check("glitch_stop", 32'(state_o), 32'(ST_ADDR));
      m_scl = 1'b0;
      wait_clks(Q);
      stop_cond();
      end_checks();

      // Reset while the slave is driving the address ACK
      slave_addr = 7'h27;
      abyte      = 8'h4E;
      if ((abyte >> 1) == {1'b0, slave_addr}) exp_hits++;
      start_cond();
      for (int i = 7; i >= 0; i--) bit_out(abyte[i]);
      check("ack_drive", {31'd0, sda_oe}, 32'd1);
      rst = 1'b1;
      wait_clks(1);
      check("rst_mid_sda", {31'd0, sda_oe}, 32'd0);
      check("rst_mid_state", 32'(state_o), 32'(ST_IDLE));
      check("rst_mid_rx", {24'd0, rx_data}, {24'd0, RX_RST_V});
      m_scl = 1'b1;
      wait_clks(2);
      m_sda = 1'b1;
      wait_clks(Q);
      rst      = 1'b0;
      model_rx = RX_RST_V;
      wait_clks(Q);
      end_checks();

      // Randomised traffic
      for (int t = 0; t < 16; t++) random_txn();

      wait_clks(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_i2c_slave_fsm
